// File: rtl/axis_irc_arb_if.sv
// rtl/axis_irc_arb_if.sv - byte-stream bundle between requesters, the packet arbiter and the IR TX sink
interface axis_irc_arb_if #(
    parameter int C_NUM_SRC = 4
);
    logic [8*C_NUM_SRC-1:0] s_axis_tdata;
    logic [C_NUM_SRC-1:0]   s_axis_tvalid;
    logic [C_NUM_SRC-1:0]   s_axis_tlast;
    logic [C_NUM_SRC-1:0]   s_axis_tready;
    logic [7:0]             m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;

    // arbiter side: sinks the requester streams, sources the TX stream
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    // environment side: drives the requesters and the TX ready
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/axis_irc_arb.sv
// rtl/axis_irc_arb.sv - round-robin packet arbiter sharing one IR UART TX among byte-stream sources
// Optional inter-frame idle gap enabled by defining IRC_ARB_GAP_EN.
module axis_irc_arb #(
    parameter int C_NUM_SRC = 4,
    parameter int C_MAX_LEN = 256
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axis_irc_arb_if.slave        axis,
    input  logic [15:0]          gap_len,
    output logic [C_NUM_SRC-1:0] grant,
    output logic                 busy
);
    localparam int W = $clog2(C_NUM_SRC);

`ifdef IRC_ARB_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1} state_t;
`endif

    state_t               state, state_nxt;
    logic [C_NUM_SRC-1:0] grant_nxt;
    logic [W-1:0]         rr_ptr, rr_ptr_nxt;
    logic [15:0]          beat_cnt, beat_cnt_nxt;
    logic                 win_found;
    logic [W-1:0]         win_idx;
    logic                 beat;
    logic                 rel;

`ifdef IRC_ARB_GAP_EN
    logic [15:0]          gap_cnt, gap_cnt_nxt;
`else
    logic                 unused_gap;
    assign unused_gap = ^gap_len;
`endif

    // rr_ptr doubles as the owner index while in S_XFER
    always_comb begin : arb_scan
        int           idx;
        logic [W-1:0] cand;
        idx       = 0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        // descending offset so the nearest valid source after rr_ptr is the last write
        for (int off = C_NUM_SRC; off >= 1; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= C_NUM_SRC) idx = idx - C_NUM_SRC;
            cand = W'(idx);
            if (axis.s_axis_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        axis.m_axis_tdata  = 8'h00;
        axis.m_axis_tvalid = 1'b0;
        axis.s_axis_tready = '0;
        beat               = 1'b0;
        if (state == S_XFER) begin
            axis.m_axis_tdata          = axis.s_axis_tdata[8*rr_ptr +: 8];
            axis.m_axis_tvalid         = axis.s_axis_tvalid[rr_ptr];
            axis.s_axis_tready[rr_ptr] = axis.m_axis_tready;
            beat = axis.s_axis_tvalid[rr_ptr] & axis.m_axis_tready;
        end
    end

    // the beat that reaches C_MAX_LEN ends the grant even without tlast
    assign rel  = beat & (axis.s_axis_tlast[rr_ptr] | ((beat_cnt + 16'd1) == 16'(C_MAX_LEN)));
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
`ifdef IRC_ARB_GAP_EN
        gap_cnt_nxt  = gap_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    grant_nxt    = C_NUM_SRC'(1) << win_idx;
                    rr_ptr_nxt   = win_idx;
                    beat_cnt_nxt = 16'd0;
                    state_nxt    = S_XFER;
                end
            end
            S_XFER: begin
                if (beat) beat_cnt_nxt = beat_cnt + 16'd1;
                if (rel) begin
                    grant_nxt = '0;
`ifdef IRC_ARB_GAP_EN
                    gap_cnt_nxt = gap_len;
                    state_nxt   = S_GAP;
`else
                    state_nxt   = S_IDLE;
`endif
                end
            end
`ifdef IRC_ARB_GAP_EN
            // a gap of N stays N cycles; zero still costs one
            S_GAP: begin
                if (gap_cnt <= 16'd1) state_nxt = S_IDLE;
                else                  gap_cnt_nxt = gap_cnt - 16'd1;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            grant    <= '0;
            rr_ptr   <= W'(C_NUM_SRC - 1);
            beat_cnt <= 16'd0;
`ifdef IRC_ARB_GAP_EN
            gap_cnt  <= 16'd0;
`endif
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
`ifdef IRC_ARB_GAP_EN
            gap_cnt  <= gap_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_axis_irc_arb.sv
// tb/tb_axis_irc_arb.sv - directed self-checking bench for axis_irc_arb
module tb_axis_irc_arb;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] gap_len = 16'd0;
    logic [3:0]  grant0, grant1;
    logic        busy0, busy1;
    int          checks = 0;
    int          errors = 0;

    always #5 aclk = ~aclk;

    axis_irc_arb_if #(.C_NUM_SRC(4)) if0 ();
    axis_irc_arb_if #(.C_NUM_SRC(4)) if1 ();

    axis_irc_arb #(.C_NUM_SRC(4), .C_MAX_LEN(256)) dut (
        .aclk(aclk), .aresetn(aresetn), .axis(if0.slave),
        .gap_len(gap_len), .grant(grant0), .busy(busy0)
    );

    axis_irc_arb #(.C_NUM_SRC(4), .C_MAX_LEN(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .axis(if1.slave),
        .gap_len(gap_len), .grant(grant1), .busy(busy1)
    );

    task automatic set0(input int i, input logic [7:0] d, input logic v, input logic l);
        if0.s_axis_tdata[8*i +: 8] = d;
        if0.s_axis_tvalid[i]       = v;
        if0.s_axis_tlast[i]        = l;
    endtask

    task automatic set1(input int i, input logic [7:0] d, input logic v, input logic l);
        if1.s_axis_tdata[8*i +: 8] = d;
        if1.s_axis_tvalid[i]       = v;
        if1.s_axis_tlast[i]        = l;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        if0.s_axis_tdata = '0; if0.s_axis_tvalid = '0; if0.s_axis_tlast = '0; if0.m_axis_tready = 1'b1;
        if1.s_axis_tdata = '0; if1.s_axis_tvalid = '0; if1.s_axis_tlast = '0; if1.m_axis_tready = 1'b1;
        gap_len = 16'd0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({grant0, busy0, if0.s_axis_tready, if0.m_axis_tvalid, if0.m_axis_tdata} !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle got grant=%b busy=%b tready=%b tvalid=%b tdata=%h exp all zero",
                     grant0, busy0, if0.s_axis_tready, if0.m_axis_tvalid, if0.m_axis_tdata);
        end
        @(negedge aclk);
        set0(2, 8'h55, 1'b1, 1'b0);
        @(negedge aclk); #1;
        checks++;
        if ({grant0, if0.s_axis_tready, busy0, if0.m_axis_tdata} !== {4'b0100, 4'b0100, 1'b1, 8'h55}) begin
            errors++;
            $display("FAIL reset_pre_xfer got grant=%b tready=%b busy=%b tdata=%h exp 0100 0100 1 55",
                     grant0, if0.s_axis_tready, busy0, if0.m_axis_tdata);
        end
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({grant0, busy0, if0.s_axis_tready, if0.m_axis_tvalid} !== 10'h0) begin
            errors++;
            $display("FAIL reset_async got grant=%b busy=%b tready=%b tvalid=%b exp all zero",
                     grant0, busy0, if0.s_axis_tready, if0.m_axis_tvalid);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) set0(i, 8'(8'h10 + i), 1'b1, 1'b1);
        @(negedge aclk); #1;
        checks++;
        if ({grant0, if0.m_axis_tdata} !== {4'b0001, 8'h10}) begin
            errors++;
            $display("FAIL reset_first_src got grant=%b tdata=%h exp 0001 10", grant0, if0.m_axis_tdata);
        end
    endtask

    task automatic test_single_pkt();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3;
        do_reset();
        @(negedge aclk);
        set0(2, bytes[0], 1'b1, 1'b0);
        #1;
        checks++;
        if (grant0 !== 4'b0000) begin
            errors++;
            $display("FAIL single_arb_latency got grant=%b exp 0000", grant0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            set0(2, bytes[k], 1'b1, k == 2);
            #1;
            checks++;
            if ({grant0, if0.m_axis_tvalid, if0.m_axis_tdata, if0.s_axis_tready} !== {4'b0100, 1'b1, bytes[k], 4'b0100}) begin
                errors++;
                $display("FAIL single_byte%0d got grant=%b tvalid=%b tdata=%h tready=%b exp 0100 1 %h 0100",
                         k, grant0, if0.m_axis_tvalid, if0.m_axis_tdata, if0.s_axis_tready, bytes[k]);
            end
        end
        @(negedge aclk);
        set0(2, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        if ({grant0, if0.m_axis_tvalid} !== 5'b0) begin
            errors++;
            $display("FAIL single_release got grant=%b tvalid=%b exp 0000 0", grant0, if0.m_axis_tvalid);
        end
    endtask

    task automatic test_round_robin();
        int k;
        k = 0;
        do_reset();
        @(negedge aclk);
        for (int i = 0; i < 4; i++) set0(i, 8'(8'h10 + i), 1'b1, 1'b1);
        for (int c = 0; c < 100 && k < 8; c++) begin
            @(negedge aclk); #1;
            if (if0.m_axis_tvalid) begin
                checks++;
                if ({grant0, if0.m_axis_tdata} !== {4'b0001 << (k % 4), 8'(8'h10 + (k % 4))}) begin
                    errors++;
                    $display("FAIL rr_order%0d got grant=%b tdata=%h exp %b %h",
                             k, grant0, if0.m_axis_tdata, 4'b0001 << (k % 4), 8'(8'h10 + (k % 4)));
                end
                k++;
            end
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL rr_count got %0d exp 8", k);
        end
    endtask

    task automatic test_max_len();
        logic [11:0] log_q [$];
        logic [11:0] exp_q [7];
        int          p;
        logic        done2;
        exp_q = '{{4'b0010, 8'hC1}, {4'b0010, 8'hC2}, {4'b0010, 8'hC3}, {4'b0010, 8'hC4},
                  {4'b0100, 8'hB0}, {4'b0010, 8'hC5}, {4'b0010, 8'hC6}};
        p = 0;
        done2 = 1'b0;
        do_reset();
        for (int c = 0; c < 40 && !(p == 6 && done2); c++) begin
            @(negedge aclk);
            set1(1, 8'(8'hC1 + p), p < 6, p == 5);
            set1(2, 8'hB0, !done2, 1'b1);
            #1;
            if (if1.m_axis_tvalid && if1.m_axis_tready) log_q.push_back({grant1, if1.m_axis_tdata});
            if (if1.s_axis_tready[1] && if1.s_axis_tvalid[1]) p++;
            if (if1.s_axis_tready[2] && if1.s_axis_tvalid[2]) done2 = 1'b1;
        end
        checks++;
        if (log_q.size() !== 7) begin
            errors++;
            $display("FAIL maxlen_count got %0d exp 7", log_q.size());
        end
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL maxlen_beat%0d got grant/data=%h exp %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got [$];
        int         p;
        p = 0;
        do_reset();
        for (int c = 0; c < 40 && p < 5; c++) begin
            @(negedge aclk);
            if0.m_axis_tready = c[0];
            set0(3, 8'(8'hD1 + p), 1'b1, p == 4);
            #1;
            if (grant0 == 4'b1000) begin
                checks++;
                if ({if0.s_axis_tready, busy0} !== {(c[0] ? 4'b1000 : 4'b0000), 1'b1}) begin
                    errors++;
                    $display("FAIL bp_cycle%0d got tready=%b busy=%b exp %b 1",
                             c, if0.s_axis_tready, busy0, c[0] ? 4'b1000 : 4'b0000);
                end
            end
            if (if0.m_axis_tvalid && if0.m_axis_tready) begin
                got.push_back(if0.m_axis_tdata);
                p++;
            end
        end
        @(negedge aclk);
        set0(3, 8'h00, 1'b0, 1'b0);
        if0.m_axis_tready = 1'b1;
        checks++;
        if (got.size() !== 5) begin
            errors++;
            $display("FAIL bp_count got %0d exp 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'(8'hD1 + i)) begin
                errors++;
                $display("FAIL bp_byte%0d got %h exp %h", i, got[i], 8'(8'hD1 + i));
            end
        end
    endtask

    task automatic run_gap(input logic [15:0] glen, input int exp_gap);
        int beats, gapc, idlec;
        beats = 0; gapc = 0; idlec = 0;
        do_reset();
        @(negedge aclk);
        gap_len = glen;
        set0(0, 8'h01, 1'b1, 1'b1);
        set0(1, 8'h02, 1'b1, 1'b1);
        for (int c = 0; c < 60 && beats < 2; c++) begin
            @(negedge aclk);
            if (beats >= 1) set0(0, 8'h00, 1'b0, 1'b0);
            if (gapc == 2) gap_len = 16'd3;
            #1;
            if (if0.m_axis_tvalid && if0.m_axis_tready) beats++;
            else if (beats == 1 && busy0 && grant0 == 4'b0000) gapc++;
            else if (beats == 1 && !busy0) idlec++;
        end
        checks++;
        if ({beats, gapc, idlec} !== {32'd2, exp_gap, 32'd1}) begin
            errors++;
            $display("FAIL gap_len%0d got beats=%0d gap=%0d idle=%0d exp 2 %0d 1",
                     glen, beats, gapc, idlec, exp_gap);
        end
    endtask

    task automatic test_gap();
`ifdef IRC_ARB_GAP_EN
        run_gap(16'd10, 10);
        run_gap(16'd0, 1);
`else
        run_gap(16'd10, 0);
`endif
    endtask

    initial begin
        if0.s_axis_tdata = '0; if0.s_axis_tvalid = '0; if0.s_axis_tlast = '0; if0.m_axis_tready = 1'b1;
        if1.s_axis_tdata = '0; if1.s_axis_tvalid = '0; if1.s_axis_tlast = '0; if1.m_axis_tready = 1'b1;
        test_reset();
        test_single_pkt();
        test_round_robin();
        test_max_len();
        test_backpressure();
        test_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
